// File: rtl/pmap_pkg.sv
// Shared types and constants for the pmap payload constellation mapper.
// Amplitudes are Q1.12 (1.0 = 4096) in a signed 14-bit container.
package pmap_pkg;

    typedef enum logic [1:0] {
        MOD_BPSK  = 2'd0,
        MOD_QPSK  = 2'd1,
        MOD_QAM16 = 2'd2,
        MOD_RSVD  = 2'd3
    } mod_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PAD  = 2'd2
    } state_t;

    localparam logic signed [13:0] AMP_BPSK   = 14'sd4096;
    localparam logic signed [13:0] AMP_QPSK   = 14'sd2896;
    localparam logic signed [13:0] AMP_QAM_HI = 14'sd3886;
    localparam logic signed [13:0] AMP_QAM_LO = 14'sd1295;

    // The reserved encoding behaves as QPSK everywhere.
    function automatic logic [2:0] bits_per_sym(input mod_t m);
        case (m)
            MOD_BPSK:  return 3'd1;
            MOD_QAM16: return 3'd4;
            default:   return 3'd2;
        endcase
    endfunction

endpackage

// File: rtl/pmap_lut.sv
// Combinational Gray mapper: modulation plus collected bits (sym[0] = b0)
// to a normalised signed I/Q point.
module pmap_lut
    import pmap_pkg::*;
(
    input  mod_t               mod,
    input  logic [3:0]         sym,
    output logic signed [13:0] re,
    output logic signed [13:0] im
);

    logic signed [13:0] mag_i;
    logic signed [13:0] mag_q;

    // NOTE: every output gets a default first so no path through the case leaves a latch.
    always_comb begin
        re    = '0;
        im    = '0;
        mag_i = '0;
        mag_q = '0;
        case (mod)
            MOD_BPSK: begin
                re = sym[0] ? AMP_BPSK : -AMP_BPSK;
            end
            MOD_QAM16: begin
                // First bit of each pair is the sign, second picks inner (1) or outer (0) level.
                mag_i = sym[1] ? AMP_QAM_LO : AMP_QAM_HI;
                mag_q = sym[3] ? AMP_QAM_LO : AMP_QAM_HI;
                re    = sym[0] ? mag_i : -mag_i;
                im    = sym[2] ? mag_q : -mag_q;
            end
            default: begin
                re = sym[0] ? AMP_QPSK : -AMP_QPSK;
                im = sym[1] ? AMP_QPSK : -AMP_QPSK;
            end
        endcase
    end

endmodule

// File: rtl/pmap.sv
// Payload constellation mapper: packs a 1-bit/cycle coded stream into BPSK,
// QPSK or 16-QAM points behind valid/ready handshakes on both sides.
module pmap
    import pmap_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         mod,
    input  logic               di,
    input  logic               di_vld,
    input  logic               di_last,
    output logic               di_rdy,
    output logic signed [13:0] do_re,
    output logic signed [13:0] do_im,
    output logic               do_vld,
    output logic               do_last,
    input  logic               do_rdy
);

    state_t             state;
    state_t             state_nxt;
    mod_t               mod_q;
    mod_t               cur_mod;
    logic [1:0]         cnt;
    logic [3:0]         sym_q;
    logic [3:0]         sym_nxt;
    logic [2:0]         bps;
    logic               stall;
    logic               accept;
    logic               pad_step;
    logic               step;
    logic               bit_in;
    logic               last_in;
    logic               complete;
    logic signed [13:0] map_re;
    logic signed [13:0] map_im;

    // The first bit of a frame arrives in IDLE, before mod_q has been loaded.
    assign cur_mod = (state == IDLE) ? mod_t'(mod) : mod_q;
    assign bps     = bits_per_sym(cur_mod);

    always_comb begin
        stall    = do_vld && !do_rdy;
        di_rdy   = (state != PAD) && !stall;
        accept   = di_vld && di_rdy;
        pad_step = (state == PAD) && !stall;
        step     = accept || pad_step;
        bit_in   = accept ? di : 1'b0;
        last_in  = accept ? di_last : 1'b1;
        complete = step && ({1'b0, cnt} == bps - 3'd1);
        sym_nxt  = sym_q;
        sym_nxt[cnt] = bit_in;
    end

    pmap_lut u_lut (
        .mod (cur_mod),
        .sym (sym_nxt),
        .re  (map_re),
        .im  (map_im)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, RUN: begin
                if (accept) begin
                    if (di_last)
                        state_nxt = complete ? IDLE : PAD;
                    else
                        state_nxt = RUN;
                end
            end
            PAD: begin
                if (complete)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            mod_q <= MOD_QPSK;
            cnt   <= '0;
            sym_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept && state == IDLE)
                mod_q <= cur_mod;
            if (step) begin
                sym_q <= sym_nxt;
                cnt   <= complete ? 2'd0 : cnt + 2'd1;
            end
        end
    end

    // Single output register; a load may coincide with a consume.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            do_re   <= '0;
            do_im   <= '0;
            do_vld  <= 1'b0;
            do_last <= 1'b0;
        end else if (complete) begin
            do_re   <= map_re;
            do_im   <= map_im;
            do_vld  <= 1'b1;
            do_last <= last_in;
        end else if (do_vld && do_rdy) begin
            do_vld  <= 1'b0;
            do_last <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pmap.sv
// Self-checking bench for pmap: a frame-level model predicts the symbol stream,
// a negedge monitor compares every consumed symbol and stall stability.
module tb_pmap;

    logic               clk = 1'b0;
    logic               rst;
    logic [1:0]         mod;
    logic               di;
    logic               di_vld;
    logic               di_last;
    logic               di_rdy;
    logic signed [13:0] do_re;
    logic signed [13:0] do_im;
    logic               do_vld;
    logic               do_last;
    logic               do_rdy;

    typedef struct {
        int re;
        int im;
        bit last;
    } exp_sym_t;

    exp_sym_t exp_q[$];
    bit       fr[$];
    int       errors = 0;
    int       checks = 0;

    bit       prev_stall = 1'b0;
    int       hold_re;
    int       hold_im;
    int       hold_last;

    pmap dut (
        .clk     (clk),
        .rst     (rst),
        .mod     (mod),
        .di      (di),
        .di_vld  (di_vld),
        .di_last (di_last),
        .di_rdy  (di_rdy),
        .do_re   (do_re),
        .do_im   (do_im),
        .do_vld  (do_vld),
        .do_last (do_last),
        .do_rdy  (do_rdy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Fill fr with n bits of v, most significant first (first bit sent = v[n-1]).
    task automatic set_bits(input logic [15:0] v, input int n);
        fr.delete();
        for (int i = 0; i < n; i++) fr.push_back(v[n-1-i]);
    endtask

    // Frame-level model: group bits, zero-pad, map with the Gray rules.
    task automatic model_frame(input int m);
        int n;
        int nsym;
        bit b[4];
        exp_sym_t e;
        n    = (m == 0) ? 1 : (m == 2) ? 4 : 2;
        nsym = (fr.size() + n - 1) / n;
        for (int s = 0; s < nsym; s++) begin
            for (int k = 0; k < 4; k++)
                b[k] = (k < n && s * n + k < fr.size()) ? fr[s * n + k] : 1'b0;
            case (m)
                0: begin
                    e.re = b[0] ? 4096 : -4096;
                    e.im = 0;
                end
                2: begin
                    e.re = (b[0] ? 1 : -1) * (b[1] ? 1295 : 3886);
                    e.im = (b[2] ? 1 : -1) * (b[3] ? 1295 : 3886);
                end
                default: begin
                    e.re = b[0] ? 2896 : -2896;
                    e.im = b[1] ? 2896 : -2896;
                end
            endcase
            e.last = (s == nsym - 1);
            exp_q.push_back(e);
        end
    endtask

    // Present one bit and return #1 after the edge that accepted it.
    task automatic send_bit(input bit b, input bit last, input logic [1:0] m);
        bit ok;
        di      = b;
        di_last = last;
        mod     = m;
        di_vld  = 1'b1;
        ok      = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (di_rdy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        di_vld  = 1'b0;
        di_last = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (prev_stall) begin
                check("stall_vld_hold", int'(do_vld), 1);
                check("stall_re_hold", int'(do_re), hold_re);
                check("stall_im_hold", int'(do_im), hold_im);
                check("stall_last_hold", int'(do_last), hold_last);
            end
            if (do_vld && do_rdy) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_symbol", 1, 0);
                end else begin
                    exp_sym_t e;
                    e = exp_q.pop_front();
                    check("sym_re", int'(do_re), e.re);
                    check("sym_im", int'(do_im), e.im);
                    check("sym_last", int'(do_last), int'(e.last));
                end
            end
            if (do_vld && !do_rdy) check("stall_di_rdy", int'(di_rdy), 0);
            prev_stall = do_vld && !do_rdy;
            hold_re    = int'(do_re);
            hold_im    = int'(do_im);
            hold_last  = int'(do_last);
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        int pad_cycles;
        rst     = 1'b0;
        mod     = 2'd0;
        di      = 1'b0;
        di_vld  = 1'b0;
        di_last = 1'b0;
        do_rdy  = 1'b1;
        #3;
        check("rst_re", int'(do_re), 0);
        check("rst_im", int'(do_im), 0);
        check("rst_vld", int'(do_vld), 0);
        check("rst_last", int'(do_last), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        check("rst_di_rdy", int'(di_rdy), 1);

        // 1: QPSK 1,0
        set_bits(16'b10, 2);
        model_frame(1);
        send_bit(1'b1, 1'b0, 2'd1);
        check("t1_vld_early", int'(do_vld), 0);
        send_bit(1'b0, 1'b1, 2'd1);
        check("t1_vld", int'(do_vld), 1);
        check("t1_re", int'(do_re), 2896);
        check("t1_im", int'(do_im), -2896);

        // 2: 16-QAM 1,0,0,1 then 0,1,1,1, mod changed after the first bit
        set_bits(16'b1001_0111, 8);
        model_frame(2);
        for (int i = 0; i < 8; i++) begin
            send_bit(fr[i], i == 7, (i == 0) ? 2'd2 : 2'd1);
            if (i == 3) begin
                check("t2_re_a", int'(do_re), 3886);
                check("t2_im_a", int'(do_im), -1295);
            end
            if (i == 7) begin
                check("t2_re_b", int'(do_re), -1295);
                check("t2_im_b", int'(do_im), 1295);
                check("t2_last_b", int'(do_last), 1);
            end
        end

        // 3: BPSK 1,0,1
        set_bits(16'b101, 3);
        model_frame(0);
        for (int i = 0; i < 3; i++) begin
            send_bit(fr[i], i == 2, (i == 0) ? 2'd0 : 2'd3);
            check("t3_vld", int'(do_vld), 1);
            check("t3_re", int'(do_re), (i == 1) ? -4096 : 4096);
            check("t3_im", int'(do_im), 0);
            check("t3_last", int'(do_last), (i == 2) ? 1 : 0);
        end

        // 4: 16-QAM 6 bits, second symbol padded
        set_bits(16'b0000_11, 6);
        model_frame(2);
        for (int i = 0; i < 6; i++) send_bit(fr[i], i == 5, (i == 0) ? 2'd2 : 2'd0);
        pad_cycles = 0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (di_rdy) break;
            pad_cycles++;
        end
        check("t4_pad_cycles", pad_cycles, 2);
        check("t4_vld", int'(do_vld), 1);
        check("t4_re", int'(do_re), 1295);
        check("t4_im", int'(do_im), -3886);
        check("t4_last", int'(do_last), 1);
        @(posedge clk);
        #1;

        // 5: QPSK stream with a 5-cycle downstream stall
        set_bits(16'b1001_1100, 8);
        model_frame(1);
        send_bit(fr[0], 1'b0, 2'd1);
        send_bit(fr[1], 1'b0, 2'd1);
        check("t5_vld", int'(do_vld), 1);
        do_rdy = 1'b0;
        fork
            begin
                for (int i = 2; i < 8; i++) send_bit(fr[i], i == 7, 2'd0);
            end
            begin
                repeat (5) begin
                    @(negedge clk);
                    check("t5_di_rdy_low", int'(di_rdy), 0);
                end
                @(posedge clk);
                #1;
                do_rdy = 1'b1;
            end
        join
        repeat (3) @(posedge clk);
        #1;
        check("t5_drained", exp_q.size(), 0);

        // 6: reset in the middle of a 16-QAM frame, then a clean QPSK frame
        send_bit(1'b1, 1'b0, 2'd2);
        send_bit(1'b1, 1'b0, 2'd2);
        send_bit(1'b0, 1'b0, 2'd2);
        #2;
        rst = 1'b0;
        #1;
        check("t6_re", int'(do_re), 0);
        check("t6_im", int'(do_im), 0);
        check("t6_vld", int'(do_vld), 0);
        check("t6_last", int'(do_last), 0);
        check("t6_di_rdy", int'(di_rdy), 1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        set_bits(16'b01, 2);
        model_frame(1);
        send_bit(1'b0, 1'b0, 2'd1);
        send_bit(1'b1, 1'b1, 2'd1);
        check("t6_post_re", int'(do_re), -2896);
        check("t6_post_im", int'(do_im), 2896);
        check("t6_post_last", int'(do_last), 1);

        repeat (5) @(posedge clk);
        #1;
        check("final_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
